// File: rtl/enigma_qos_merge.sv
// enigma_qos_merge: N-port QoS merge arbiter onto one registered output port.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   s_payload/s_id/s_qos/s_valid    packed per-port request fields (port i at slice i)
//   s_ready                         one-hot grant, combinational, 0 while in reset
//   m_payload/m_id/m_qos/m_valid    registered output; m_id = {port index, s_id}
//   m_ready, m_conflict             downstream handshake; conflict refuses the transfer
//   m_release, m_releaseid          frees an outstanding extended ID
//   cnt_conflict                    saturating count of refused transfers
//   err_release                     sticky bad-release flag
//
// Arbitration picks the highest effective QoS among eligible ports, breaking ties
// round-robin from rr_ptr. A port starved for AGE_LIMIT cycles is promoted to QMAX.
// An outstanding bit per extended ID blocks a second same-ID request until release.
module enigma_qos_merge #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned PAYLOAD_W = 128,
  parameter int unsigned ID_W      = 5,
  parameter int unsigned QOS_W     = 2,
  parameter int unsigned AGE_LIMIT = 15,
  localparam int unsigned PW       = $clog2(NUM_PORTS),
  localparam int unsigned XW       = ID_W + PW
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS*PAYLOAD_W-1:0] s_payload,
  input  logic [NUM_PORTS*ID_W-1:0]      s_id,
  input  logic [NUM_PORTS*QOS_W-1:0]     s_qos,
  input  logic [NUM_PORTS-1:0]           s_valid,
  output logic [NUM_PORTS-1:0]           s_ready,
  output logic [PAYLOAD_W-1:0]           m_payload,
  output logic [XW-1:0]                  m_id,
  output logic [QOS_W-1:0]               m_qos,
  output logic                           m_valid,
  input  logic                           m_ready,
  input  logic                           m_conflict,
  input  logic                           m_release,
  input  logic [XW-1:0]                  m_releaseid,
  output logic [15:0]                    cnt_conflict,
  output logic                           err_release
);

  localparam int unsigned AW = $clog2(AGE_LIMIT + 1);
  localparam int unsigned OT = 1 << XW;
  localparam logic [QOS_W-1:0] QMAX = '1;

  logic [PAYLOAD_W-1:0] m_payload_q, m_payload_d;
  logic [XW-1:0]        m_id_q, m_id_d;
  logic [QOS_W-1:0]     m_qos_q, m_qos_d;
  logic                 m_valid_q, m_valid_d;
  logic [OT-1:0]        out_q, out_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]        age_q [NUM_PORTS];
  logic [AW-1:0]        age_d [NUM_PORTS];
  logic [15:0]          cnt_conflict_q, cnt_conflict_d;
  logic                 err_release_q, err_release_d;

  logic                 accept, refuse, load_en, found, grant;
  logic [NUM_PORTS-1:0] elig;
  logic [QOS_W-1:0]     eff_q [NUM_PORTS];
  logic [QOS_W-1:0]     max_q;
  logic [PW-1:0]        win;
  logic [XW-1:0]        set_idx;
  int unsigned          scan_idx;

  assign accept  = m_valid_q & m_ready & ~m_conflict;
  assign refuse  = m_valid_q & m_ready & m_conflict;
  assign load_en = ~m_valid_q | accept;

  // Arbitration: eligibility, effective QoS, max search, then round-robin scan.
  always_comb begin
    elig     = '0;
    max_q    = '0;
    found    = 1'b0;
    win      = '0;
    scan_idx = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      elig[i]  = s_valid[i] & ~out_q[{PW'(i), s_id[i*ID_W +: ID_W]}];
      eff_q[i] = (age_q[i] == AW'(AGE_LIMIT)) ? QMAX : s_qos[i*QOS_W +: QOS_W];
      if (elig[i] && eff_q[i] > max_q) max_q = eff_q[i];
    end
    for (int k = 0; k < NUM_PORTS; k++) begin
      scan_idx = (int'(rr_ptr_q) + k) % NUM_PORTS;
      if (!found && elig[scan_idx] && eff_q[scan_idx] == max_q) begin
        found = 1'b1;
        win   = PW'(scan_idx);
      end
    end
  end

  assign grant   = load_en & found;
  assign set_idx = {win, s_id[int'(win)*ID_W +: ID_W]};

  always_comb begin
    s_ready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      s_ready[i] = grant & (win == PW'(i)) & rst_n;
    end
  end

  always_comb begin
    m_payload_d    = m_payload_q;
    m_id_d         = m_id_q;
    m_qos_d        = m_qos_q;
    m_valid_d      = m_valid_q;
    out_d          = out_q;
    rr_ptr_d       = rr_ptr_q;
    cnt_conflict_d = cnt_conflict_q;
    err_release_d  = err_release_q;

    if (refuse && cnt_conflict_q != 16'hFFFF) cnt_conflict_d = cnt_conflict_q + 16'd1;

    if (grant) begin
      m_payload_d = s_payload[int'(win)*PAYLOAD_W +: PAYLOAD_W];
      m_id_d      = set_idx;
      m_qos_d     = s_qos[int'(win)*QOS_W +: QOS_W];
      m_valid_d   = 1'b1;
      rr_ptr_d    = PW'((int'(win) + 1) % NUM_PORTS);
    end else if (accept) begin
      m_valid_d = 1'b0;
    end

    // Release first so a coincident set of the same ID overrides the clear.
    if (m_release) begin
      if (grant && set_idx == m_releaseid) begin
        err_release_d = 1'b1;
      end else if (!out_q[m_releaseid]) begin
        err_release_d = 1'b1;
      end else begin
        out_d[m_releaseid] = 1'b0;
      end
    end
    if (grant) out_d[set_idx] = 1'b1;

    for (int i = 0; i < NUM_PORTS; i++) begin
      age_d[i] = age_q[i];
      if (!s_valid[i] || (grant && win == PW'(i))) begin
        age_d[i] = '0;
      end else if (age_q[i] != AW'(AGE_LIMIT)) begin
        age_d[i] = age_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_payload_q    <= '0;
      m_id_q         <= '0;
      m_qos_q        <= '0;
      m_valid_q      <= 1'b0;
      out_q          <= '0;
      rr_ptr_q       <= '0;
      cnt_conflict_q <= '0;
      err_release_q  <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) age_q[i] <= '0;
    end else begin
      m_payload_q    <= m_payload_d;
      m_id_q         <= m_id_d;
      m_qos_q        <= m_qos_d;
      m_valid_q      <= m_valid_d;
      out_q          <= out_d;
      rr_ptr_q       <= rr_ptr_d;
      cnt_conflict_q <= cnt_conflict_d;
      err_release_q  <= err_release_d;
      for (int i = 0; i < NUM_PORTS; i++) age_q[i] <= age_d[i];
    end
  end

  assign m_payload    = m_payload_q;
  assign m_id         = m_id_q;
  assign m_qos        = m_qos_q;
  assign m_valid      = m_valid_q;
  assign cnt_conflict = cnt_conflict_q;
  assign err_release  = err_release_q;

endmodule

// File: tb/tb_enigma_qos_merge.sv
module tb_enigma_qos_merge;

  logic clk;
  logic rst_n;

  // Two-port instance (default parameters)
  logic [255:0] s_payload;
  logic [9:0]   s_id;
  logic [3:0]   s_qos;
  logic [1:0]   s_valid;
  logic [1:0]   s_ready;
  logic [127:0] m_payload;
  logic [5:0]   m_id;
  logic [1:0]   m_qos;
  logic         m_valid;
  logic         m_ready;
  logic         m_conflict;
  logic         m_release;
  logic [5:0]   m_releaseid;
  logic [15:0]  cnt_conflict;
  logic         err_release;

  // Four-port instance, ID_W=3
  logic [511:0] s_payload4;
  logic [11:0]  s_id4;
  logic [7:0]   s_qos4;
  logic [3:0]   s_valid4;
  logic [3:0]   s_ready4;
  logic [127:0] m_payload4;
  logic [4:0]   m_id4;
  logic [1:0]   m_qos4;
  logic         m_valid4;
  logic         m_ready4;
  logic [15:0]  cnt_conflict4;
  logic         err_release4;

  enigma_qos_merge u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_payload(s_payload), .s_id(s_id), .s_qos(s_qos), .s_valid(s_valid), .s_ready(s_ready),
    .m_payload(m_payload), .m_id(m_id), .m_qos(m_qos), .m_valid(m_valid),
    .m_ready(m_ready), .m_conflict(m_conflict), .m_release(m_release),
    .m_releaseid(m_releaseid), .cnt_conflict(cnt_conflict), .err_release(err_release)
  );

  enigma_qos_merge #(.NUM_PORTS(4), .ID_W(3)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .s_payload(s_payload4), .s_id(s_id4), .s_qos(s_qos4), .s_valid(s_valid4),
    .s_ready(s_ready4), .m_payload(m_payload4), .m_id(m_id4), .m_qos(m_qos4),
    .m_valid(m_valid4), .m_ready(m_ready4), .m_conflict(1'b0), .m_release(1'b0),
    .m_releaseid(5'd0), .cnt_conflict(cnt_conflict4), .err_release(err_release4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]   id;
    logic [1:0]   qos;
    logic [127:0] pl;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic auto_rel = 1'b0;
  logic [127:0] pat_a5;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic [4:0] id, input logic [1:0] qos,
                          input logic [127:0] pl, input logic v);
    s_id[p*5 +: 5]        = id;
    s_qos[p*2 +: 2]       = qos;
    s_payload[p*128 +: 128] = pl;
    s_valid[p]            = v;
  endtask

  task automatic push_exp(input int p, input logic [4:0] id, input logic [1:0] qos,
                          input logic [127:0] pl);
    exp_t e;
    e.id  = {p[0], id};
    e.qos = qos;
    e.pl  = pl;
    sb.push_back(e);
  endtask

  // Called at posedge+1 with inputs set; checks grant, scores accepts, advances one cycle.
  task automatic tick(input string tag, input logic [1:0] exp_ready);
    exp_t e;
    if (auto_rel) begin
      m_release   = m_valid & m_ready & ~m_conflict;
      m_releaseid = m_id;
    end
    #1;
    chk(tag, {126'd0, s_ready}, {126'd0, exp_ready});
    if (m_valid && m_ready && !m_conflict) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_underflow observed=output expected=none");
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_id", {122'd0, m_id}, {122'd0, e.id});
        chk("sb_qos", {126'd0, m_qos}, {126'd0, e.qos});
        chk("sb_payload", m_payload, e.pl);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_valid = '0;
    m_release = 1'b0;
    m_conflict = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    pat_a5 = {16{8'hA5}};
    rst_n = 1'b0;
    s_payload = '0; s_id = '0; s_qos = '0; s_valid = '0;
    m_ready = 1'b1; m_conflict = 1'b0; m_release = 1'b0; m_releaseid = '0;
    s_payload4 = '0; s_id4 = '0; s_qos4 = '0; s_valid4 = '0; m_ready4 = 1'b0;
    #1;
    chk("reset_ready", {126'd0, s_ready}, 128'd0);
    do_reset();
    chk("reset_mvalid", {127'd0, m_valid}, 128'd0);
    chk("reset_mid", {122'd0, m_id}, 128'd0);
    chk("reset_payload", m_payload, 128'd0);
    chk("reset_cnt", {112'd0, cnt_conflict}, 128'd0);
    chk("reset_err", {127'd0, err_release}, 128'd0);

    // Equal QoS round-robin with continuous release
    auto_rel = 1'b1;
    set_port(0, 5'd3, 2'd1, 128'h100, 1'b1);
    set_port(1, 5'd9, 2'd1, 128'h200, 1'b1);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) chk("rr_one_per_cycle", {127'd0, m_valid}, 128'd1);
      if (k % 2 == 0) begin
        push_exp(0, 5'd3, 2'd1, 128'h100);
        tick("rr_ready", 2'b01);
      end else begin
        push_exp(1, 5'd9, 2'd1, 128'h200);
        tick("rr_ready", 2'b10);
      end
    end
    s_valid = '0;
    tick("rr_drain", 2'b00);
    chk("rr_empty", {127'd0, m_valid}, 128'd0);

    // Aging promotes the starved low-QoS port on the 16th arbitration
    do_reset();
    auto_rel = 1'b1;
    set_port(1, 5'd7, 2'd0, 128'h7000, 1'b1);
    for (int k = 0; k < 17; k++) begin
      set_port(0, 5'(k), 2'd3, 128'h3000 + 128'(k), 1'b1);
      if (k == 15) begin
        push_exp(1, 5'd7, 2'd0, 128'h7000);
        tick("age_ready", 2'b10);
      end else begin
        push_exp(0, 5'(k), 2'd3, 128'h3000 + 128'(k));
        tick("age_ready", 2'b01);
      end
    end
    s_valid = '0;
    tick("age_drain", 2'b00);

    // Same-ID ordering via outstanding table
    do_reset();
    auto_rel = 1'b0;
    set_port(0, 5'd5, 2'd1, 128'h51, 1'b1);
    push_exp(0, 5'd5, 2'd1, 128'h51);
    tick("ord_first", 2'b01);
    set_port(0, 5'd5, 2'd1, 128'h52, 1'b1);
    set_port(1, 5'd2, 2'd1, 128'h12, 1'b1);
    push_exp(1, 5'd2, 2'd1, 128'h12);
    tick("ord_block1", 2'b10);
    set_port(1, 5'd3, 2'd1, 128'h13, 1'b1);
    push_exp(1, 5'd3, 2'd1, 128'h13);
    tick("ord_block2", 2'b10);
    s_valid[1] = 1'b0;
    m_release = 1'b1;
    m_releaseid = 6'h05;
    tick("ord_rel_cycle", 2'b00);
    m_release = 1'b0;
    push_exp(0, 5'd5, 2'd1, 128'h52);
    tick("ord_after_rel", 2'b01);
    s_valid = '0;
    tick("ord_drain", 2'b00);
    chk("ord_no_err", {127'd0, err_release}, 128'd0);

    // Conflict holds the output and counts refusals
    do_reset();
    set_port(0, 5'd1, 2'd2, pat_a5, 1'b1);
    push_exp(0, 5'd1, 2'd2, pat_a5);
    tick("cf_grant", 2'b01);
    s_valid[0] = 1'b0;
    set_port(1, 5'd4, 2'd1, 128'h44, 1'b1);
    m_conflict = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("cf_hold_valid", {127'd0, m_valid}, 128'd1);
      chk("cf_hold_payload", m_payload, pat_a5);
      tick("cf_no_ready", 2'b00);
    end
    chk("cf_hold_id", {122'd0, m_id}, 128'd1);
    chk("cf_count", {112'd0, cnt_conflict}, 128'd3);
    m_conflict = 1'b0;
    push_exp(1, 5'd4, 2'd1, 128'h44);
    tick("cf_accept", 2'b10);
    s_valid = '0;
    tick("cf_drain", 2'b00);
    chk("cf_count_final", {112'd0, cnt_conflict}, 128'd3);

    // Release of a never-issued ID sets sticky error, table unchanged
    set_port(0, 5'd1, 2'd1, 128'h61, 1'b1);
    m_release = 1'b1;
    m_releaseid = 6'h3F;
    chk("err_before", {127'd0, err_release}, 128'd0);
    tick("err_rel_cycle", 2'b00);
    m_release = 1'b0;
    chk("err_set", {127'd0, err_release}, 128'd1);
    set_port(1, 5'd31, 2'd0, 128'h1F, 1'b1);
    push_exp(1, 5'd31, 2'd0, 128'h1F);
    tick("err_table_intact", 2'b10);
    s_valid = '0;
    tick("err_drain", 2'b00);
    chk("err_sticky", {127'd0, err_release}, 128'd1);

    // Four-port instance: async reset with held output, then first grant
    s_valid4 = 4'b0100;
    s_id4[6 +: 3] = 3'd3;
    s_qos4[4 +: 2] = 2'd1;
    s_payload4[256 +: 128] = 128'hCC;
    @(posedge clk);
    #1;
    chk("p4_held_valid", {127'd0, m_valid4}, 128'd1);
    chk("p4_held_id", {123'd0, m_id4}, {123'd0, 5'b10011});
    #2 rst_n = 1'b0;
    #1;
    chk("p4_rst_valid", {127'd0, m_valid4}, 128'd0);
    chk("p4_rst_id", {123'd0, m_id4}, 128'd0);
    chk("p4_rst_payload", m_payload4, 128'd0);
    chk("p4_rst_qos", {126'd0, m_qos4}, 128'd0);
    chk("p4_rst_mvalid2", {127'd0, m_valid}, 128'd0);
    s_valid4 = 4'b1111;
    s_qos4 = {4{2'd2}};
    s_id4 = {3'd3, 3'd2, 3'd1, 3'd0};
    #1;
    chk("p4_rst_ready", {124'd0, s_ready4}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("p4_first_ready", {124'd0, s_ready4}, 128'd1);
    @(posedge clk);
    #1;
    chk("p4_first_valid", {127'd0, m_valid4}, 128'd1);
    chk("p4_first_id", {123'd0, m_id4}, 128'd0);

    chk("sb_drained", 128'(sb.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/enigma_qos_merge.md
# enigma_qos_merge

N-port QoS merge arbiter for the enigma datapath, and the parametrised successor of the fixed two-port A/B→C merge. It accepts tagged requests on NUM_PORTS valid/ready input ports and merges them onto one registered output port. Arbitration is by QoS with round-robin tie-break and anti-starvation aging. Per-ID ordering is enforced with an outstanding table that the downstream frees through release, and the downstream can refuse a transfer through conflict.

## Interface
- NUM_PORTS, 2: input port count, ≥2; PW = clog2(NUM_PORTS)
- PAYLOAD_W, 128: payload width
- ID_W, 5: input ID width; output/extended ID width XW = ID_W+PW
- QOS_W, 2: QoS width; QMAX = 2^QOS_W−1
- AGE_LIMIT, 15: starvation cycles before promotion to QMAX, ≥1; counter width clog2(AGE_LIMIT+1)

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_payload  in  NUM_PORTS*PAYLOAD_W  packed per-port payload, port i at [i*PAYLOAD_W +: PAYLOAD_W]
- s_id  in  NUM_PORTS*ID_W  packed per-port ID
- s_qos  in  NUM_PORTS*QOS_W  packed per-port QoS
- s_valid  in  NUM_PORTS  per-port request valid
- s_ready  out  NUM_PORTS  per-port grant; combinational; forced 0 while rst_n low
- m_payload  out  PAYLOAD_W  output payload, registered
- m_id  out  XW  {port index, s_id}, registered
- m_qos  out  QOS_W  original (unpromoted) QoS, registered
- m_valid  out  1  output valid
- m_ready  in  1  downstream ready
- m_conflict  in  1  qualifies m_valid&m_ready; 1 = transfer refused
- m_release  in  1  frees outstanding extended ID m_releaseid
- m_releaseid  in  XW  ID being released
- cnt_conflict  out  16  saturating count of refused transfers
- err_release  out  1  sticky; release of a non-outstanding ID, or release coinciding with a set of the same ID

## Operation
- Accept = m_valid & m_ready & ~m_conflict. Refuse = m_valid & m_ready & m_conflict: output register holds its contents, cnt_conflict += 1 (saturates at 0xFFFF).
- Load enable = ~m_valid | accept. The output register therefore sustains one transfer per cycle.
- Eligible[i] = s_valid[i] & ~outstanding[{i, s_id[i]}].
- Effective QoS[i] = QMAX if age[i] == AGE_LIMIT, else s_qos[i].
- Winner: highest effective QoS among eligible ports. Ties go to the first eligible port at or after rr_ptr, searching upward with wrap.
- Grant only when load enable is 1. s_ready = one-hot of winner, or 0.
- On grant to port w:
  - output register ← port w fields
  - outstanding[{w, s_id[w]}] ← 1
  - rr_ptr ← (w+1) mod NUM_PORTS
- Outstanding table: 2^XW bits. Set at load, not at accept, so a same-ID request cannot overtake one held in the output register. A refusal does not clear the bit. m_release clears the bit for m_releaseid.
- Simultaneous set and release of the same ID: set wins; err_release ← 1.
- Release of an ID whose bit is 0: no state change; err_release ← 1.
- Aging, per port:
  - age ← 0 if ~s_valid or granted
  - else age ← min(age+1, AGE_LIMIT)
  - Ports blocked only by the outstanding table age as well.

## Timing
- Reset (async assert, sync-safe deassert): m_valid=0, m_payload=0, m_id=0, m_qos=0, outstanding=0, rr_ptr=0, all ages=0, cnt_conflict=0, err_release=0, s_ready=0.
- Latency: input handshake in cycle N → m_valid=1 with that data from cycle N+1.
- Accept in cycle N with a new grant in cycle N → new data in N+1, no bubble.
- m_payload, m_id and m_qos are stable while m_valid & ~accept.
- Release in cycle N takes effect from N+1: a same-ID request is eligible in N+1, not in N.
- Age reaches AGE_LIMIT after AGE_LIMIT consecutive un-granted valid cycles. Promotion applies in the next arbitration.
- Reset mid-operation: all state is discarded immediately. The held output is lost; upstream must re-present requests.

## Test plan
- NUM_PORTS=2, both valid, qos 1 and 1, distinct IDs, m_ready=1, continuous release → grants alternate 0,1,0,1; m_id MSB alternates; one output per cycle.
- Port0 qos=3, port1 qos=0, both continuously valid, AGE_LIMIT=15 → port0 wins 15 cycles; on the 16th arbitration port1 wins with m_qos=0.
- Port0 sends id 5, no release, then presents id 5 again → second request stalls (s_ready[0]=0) while port1 flows. Release 6'h05 → port0 granted the next cycle.
- m_conflict=1 for 3 handshake cycles on payload 0xA5.. → m_valid held with identical data, cnt_conflict=3, no s_ready asserted. Accepted on the 4th cycle.
- Release of a never-issued ID 6'h3F → err_release=1 and stays 1; the outstanding table is unchanged.
- NUM_PORTS=4, ID_W=3, reset asserted with m_valid=1 → all outputs 0 asynchronously. After deassert, the first grant goes to port 0 with all ports tied at equal QoS.
